// File: rtl/baccarat_round_ctrl.sv
`timescale 1ns/1ps
// Baccarat round sequencer: deals the four opening cards on card_rdy, applies natural and
// third-card rules, latches the outcome lights and keeps saturating per-outcome win tallies.
module baccarat_round_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int NAT_THRESH   = 8,
  parameter int STAND_THRESH = 6,
  parameter int CNT_W        = 8
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic               card_rdy,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               round_done,
  output logic [CNT_W-1:0]   player_wins,
  output logic [CNT_W-1:0]   dealer_wins,
  output logic [CNT_W-1:0]   ties
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEAL_P1 = 4'd1,
    S_DEAL_D1 = 4'd2,
    S_DEAL_P2 = 4'd3,
    S_DEAL_D2 = 4'd4,
    S_EVAL2   = 4'd5,
    S_DEAL_P3 = 4'd6,
    S_EVAL3   = 4'd7,
    S_DEAL_D3 = 4'd8,
    S_SETTLE  = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  localparam logic [SCORE_W-1:0] L_NAT   = SCORE_W'(NAT_THRESH);
  localparam logic [SCORE_W-1:0] L_STAND = SCORE_W'(STAND_THRESH);

  state_t           r_state;
  state_t           w_next;
  logic             r_pl;
  logic             r_dl;
  logic             r_done;
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_dw;
  logic [CNT_W-1:0] r_tw;
  logic             w_dealer_draw3;
  logic             w_state_ok;

  assign w_state_ok = (r_state <= S_DONE);

  always_ff @(posedge slow_clock) begin
    if (resetb) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Dealer third-card table once the player has drawn; dscore >= 7 always stands.
  always_comb begin
    w_dealer_draw3 = 1'b0;
    if (dscore <= SCORE_W'(2))
      w_dealer_draw3 = 1'b1;
    else if (dscore == SCORE_W'(3))
      w_dealer_draw3 = (pcard3 != 4'd8);
    else if (dscore == SCORE_W'(4))
      w_dealer_draw3 = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
    else if (dscore == SCORE_W'(5))
      w_dealer_draw3 = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
    else if (dscore == SCORE_W'(6))
      w_dealer_draw3 = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start)    w_next = S_DEAL_P1;
      S_DEAL_P1: if (card_rdy) w_next = S_DEAL_D1;
      S_DEAL_D1: if (card_rdy) w_next = S_DEAL_P2;
      S_DEAL_P2: if (card_rdy) w_next = S_DEAL_D2;
      S_DEAL_D2: if (card_rdy) w_next = S_EVAL2;
      S_EVAL2: begin
        if (pscore >= L_NAT || dscore >= L_NAT) w_next = S_SETTLE;
        else if (pscore < L_STAND)              w_next = S_DEAL_P3;
        else if (dscore < L_STAND)              w_next = S_DEAL_D3;
        else                                    w_next = S_SETTLE;
      end
      S_DEAL_P3: if (card_rdy) w_next = S_EVAL3;
      S_EVAL3:   w_next = w_dealer_draw3 ? S_DEAL_D3 : S_SETTLE;
      S_DEAL_D3: if (card_rdy) w_next = S_SETTLE;
      S_SETTLE:  w_next = S_DONE;
      S_DONE:    if (start)    w_next = S_DEAL_P1;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outcome is captured from the final totals on the SETTLE edge.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      r_pl   <= 1'b0;
      r_dl   <= 1'b0;
      r_done <= 1'b0;
      r_pw   <= '0;
      r_dw   <= '0;
      r_tw   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_SETTLE) begin
        r_pl   <= (pscore >= dscore);
        r_dl   <= (dscore >= pscore);
        r_done <= 1'b1;
        if (pscore > dscore) begin
          if (r_pw != '1) r_pw <= r_pw + 1'b1;
        end else if (dscore > pscore) begin
          if (r_dw != '1) r_dw <= r_dw + 1'b1;
        end else begin
          if (r_tw != '1) r_tw <= r_tw + 1'b1;
        end
      end else if ((r_state == S_DONE && start) || !w_state_ok) begin
        r_pl <= 1'b0;
        r_dl <= 1'b0;
      end
    end
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_dcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_dcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard3      = 1'b0;
    busy             = 1'b0;
    player_win_light = r_pl & w_state_ok;
    dealer_win_light = r_dl & w_state_ok;
    round_done       = r_done & w_state_ok;
    case (r_state)
      S_DEAL_P1: load_pcard1 = card_rdy;
      S_DEAL_D1: load_dcard1 = card_rdy;
      S_DEAL_P2: load_pcard2 = card_rdy;
      S_DEAL_D2: load_dcard2 = card_rdy;
      S_DEAL_P3: load_pcard3 = card_rdy;
      S_DEAL_D3: load_dcard3 = card_rdy;
      default:   ;
    endcase
    if (r_state >= S_DEAL_P1 && r_state <= S_SETTLE) busy = 1'b1;
  end

  assign player_wins = r_pw;
  assign dealer_wins = r_dw;
  assign ties        = r_tw;

endmodule

// File: doc/baccarat_round_ctrl.md
# baccarat_round_ctrl

Parametrised round controller for the baccarat datapath, and the next generation of the fixed dealing state machine. It sequences the four opening cards and applies the natural and third-card rules, with stand/natural thresholds as parameters. Each card load waits on a card-source ready handshake, and rounds are started explicitly and can repeat. Per-outcome saturating win tallies are kept across rounds. It sits between the card source / score datapath and the win lights and score display.

## Interface
- SCORE_W, default 4: width of dscore/pscore (hand total mod 10).
- NAT_THRESH, default 8: a two-card total ≥ NAT_THRESH on either hand is a natural and ends the round.
- STAND_THRESH, default 6: the player draws when pscore < STAND_THRESH. With the player standing, the dealer draws when dscore < STAND_THRESH.
- CNT_W, default 8: width of each win tally.

Ports:
- slow_clock  in  1  Clock; all state changes on its rising edge.
- resetb  in  1  Synchronous, active-high reset.
- start  in  1  Begin a round. Sampled only in IDLE or DONE.
- card_rdy  in  1  Card source has a card available this cycle.
- pscore  in  SCORE_W  Player hand total from the datapath.
- dscore  in  SCORE_W  Dealer hand total from the datapath.
- pcard3  in  4  Value 0–9 of the player's third card. Valid from the cycle after load_pcard3.
- load_pcard1, load_pcard2, load_pcard3  out  1  One-cycle player card load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1  One-cycle dealer card load strobes.
- player_win_light, dealer_win_light  out  1  Round outcome. Both high means a tie.
- busy  out  1  High from DEAL_P1 through SETTLE inclusive.
- round_done  out  1  One-cycle pulse on the first DONE cycle.
- player_wins, dealer_wins, ties  out  CNT_W  Saturating outcome tallies.

## Operation
States and transitions:
- IDLE: start → DEAL_P1.
- DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2, each advancing only when card_rdy=1.
- DEAL_D2 → EVAL2.
- EVAL2:
  - pscore ≥ NAT_THRESH or dscore ≥ NAT_THRESH → SETTLE.
  - Else pscore < STAND_THRESH → DEAL_P3.
  - Else dscore < STAND_THRESH → DEAL_D3.
  - Else → SETTLE.
- DEAL_P3 → EVAL3, advancing only when card_rdy=1.
- EVAL3: the dealer draws (→ DEAL_D3) when any of the following holds, otherwise → SETTLE:
  - dscore ≤ 2
  - dscore = 3 and pcard3 ≠ 8
  - dscore = 4 and pcard3 in 2..7
  - dscore = 5 and pcard3 in 4..7
  - dscore = 6 and pcard3 in 6..7
  - (dscore ≥ 7 always stands.)
- DEAL_D3 → SETTLE, advancing only when card_rdy=1.
- SETTLE → DONE. On this edge:
  - Lights and tallies are registered: pscore > dscore → player; dscore > pscore → dealer; equal → both lights and ties.
  - The matching tally increments, holding at 2^CNT_W−1.
- DONE: lights held. start → clear both lights, → DEAL_P1.

Load strobes:
- In a DEAL_x state the matching strobe equals card_rdy (combinational). All other strobes are 0.
- Exactly one strobe is issued per DEAL state visit, never two in the same cycle.

Other rules:
- start while busy is ignored.
- Unused state encodings → IDLE on the next edge, all outputs 0.
- Reset values: state IDLE, all strobes 0, both lights 0, busy 0, round_done 0, all tallies 0.
- resetb mid-round aborts on the next edge. The tally is not incremented and lights are cleared.

## Timing
- The datapath updates scores on the same edge as a load strobe. The EVAL states therefore see post-load totals one cycle later.
- Minimum natural round with card_rdy held high, start sampled at edge 0:
  - DEAL_P1 is cycles 1–4 (one DEAL state per cycle).
  - EVAL2 is cycle 5, SETTLE cycle 6.
  - DONE with round_done and lights is cycle 7.
- Full six-card round completes (DONE) at cycle 10.
- Each cycle card_rdy is low in a DEAL state adds exactly one cycle, with no strobe.
- From DONE, start at edge n clears the lights, and load_pcard1 can assert in cycle n+1.

## Test plan
- Natural: card_rdy=1; pscore=8, dscore=3 at EVAL2 → no third-card strobes; player_win_light=1, dealer_win_light=0, player_wins=1, round_done pulse at cycle 7.
- Player draws, dealer rule: pscore=4, dscore=6, pcard3=7 → load_pcard3 then load_dcard3. Repeating with pcard3=5 → no load_dcard3.
- Tie and stall: pscore=dscore=7 at EVAL2, card_rdy low for 3 cycles during DEAL_D1 → DONE at cycle 10, both lights high, ties=1, no strobe during the stall.
- Saturation (CNT_W=2): four consecutive dealer wins → dealer_wins sequence 1, 2, 3, 3.
- Reset mid-round: resetb high during DEAL_P3 → next cycle IDLE, all outputs and tallies 0; start ignored while busy.
- Dealer draws after player stands: pscore=6, dscore=5 → load_dcard3 only, never load_pcard3.
